// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> multiply/divide unit handshake bundle.
// The master is the execute stage; the slave is mdu_ctrl.
interface mdu_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  stall, done, busy, hi, lo
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output stall, done, busy, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Divider is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU complete in one cycle as no-ops.
module mdu_ctrl #(
    parameter int N_ITER = 32
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
`ifdef MDU_DIV_EN
    logic        rneg_q;
    logic [31:0] dividend_q;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
`endif
    logic        accept;
    logic [63:0] acc_step;
    logic [63:0] mul_res;

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        logic signed [31:0] sv;
        sv = signed'(v);
        return neg32(v, is_signed && (sv < 0));
    endfunction

    // acc = {partial product, remaining multiplier bits}; the low bit selects the add.
    function automatic logic [63:0] mul_step(input logic [63:0] p, input logic [31:0] m);
        logic [32:0] sum;
        sum = {1'b0, p[63:32]} + {1'b0, (p[0] ? m : 32'd0)};
        return {sum, p[31:1]};
    endfunction

    // acc = {remainder, quotient}; remainder < divisor so the shifted value fits 33 bits.
    function automatic logic [63:0] div_step(input logic [63:0] rq, input logic [31:0] d);
        logic [32:0] sh;
        logic [31:0] r;
        sh = {rq[63:32], rq[31]};
        if (sh >= {1'b0, d}) begin
            r = 32'(sh - {1'b0, d});
            return {r, rq[30:0], 1'b1};
        end
        return {sh[31:0], rq[30:0], 1'b0};
    endfunction

    assign accept = (state == IDLE) && bus.req_valid && !bus.flush;

    always_comb begin
        acc_step = acc;
`ifdef MDU_DIV_EN
        if (is_div_q)
            acc_step = div_step(acc, opnd);
        else
            acc_step = mul_step(acc, opnd);
`else
        acc_step = mul_step(acc, opnd);
`endif
        mul_res = neg64(acc, neg_q);
    end

`ifdef MDU_DIV_EN
    // A zero divisor leaves opnd == 0, which overrides the iterated result.
    always_comb begin
        div_lo = (opnd == 32'd0) ? 32'hFFFF_FFFF : neg32(acc[31:0], neg_q);
        div_hi = (opnd == 32'd0) ? dividend_q    : neg32(acc[63:32], rneg_q);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MDU_DIV_EN
            rneg_q     <= 1'b0;
            dividend_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_div_q <= bus.req_op[1];
                        if (bus.req_op[1]) begin
`ifdef MDU_DIV_EN
                            acc        <= {32'd0, mag32(bus.src_a, bus.req_op[0])};
                            opnd       <= mag32(bus.src_b, bus.req_op[0]);
                            neg_q      <= bus.req_op[0] & (bus.src_a[31] ^ bus.src_b[31]);
                            rneg_q     <= bus.req_op[0] & bus.src_a[31];
                            dividend_q <= bus.src_a;
                            state      <= BUSY;
`else
                            state      <= DONE;
`endif
                        end else begin
                            acc   <= {32'd0, mag32(bus.src_b, bus.req_op[0])};
                            opnd  <= mag32(bus.src_a, bus.req_op[0]);
                            neg_q <= bus.req_op[0] & (bus.src_a[31] ^ bus.src_b[31]);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 5'd1;
                        if (cnt == LAST_CNT)
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!bus.flush) begin
`ifdef MDU_DIV_EN
                        if (is_div_q)
                            {hi_q, lo_q} <= {div_hi, div_lo};
                        else
                            {hi_q, lo_q} <= mul_res;
`else
                        if (!is_div_q)
                            {hi_q, lo_q} <= mul_res;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs must drop with reset even while clk is stopped.
    assign bus.stall = !reset && (accept || (state == BUSY));
    assign bus.done  = !reset && (state == DONE) && !bus.flush;
    assign bus.busy  = !reset && (state != IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: fixed-latency mul/div results, flush, reset and the optional divider.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mdu_ctrl_if bus();

    mdu_ctrl #(.N_ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1 of the accept cycle T, returns at posedge+1 of T+35.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag, input bit flush_in_done);
        int early;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.src_a     = a;
        bus.src_b     = b;
        #1 chk({tag, "_stall_T"}, 64'(bus.stall), 64'd1);
        next();
        bus.req_valid = 1'b0;
        early = 0;
        for (int c = 1; c <= 32; c++) begin
            #1;
            if (bus.done !== 1'b0 || bus.stall !== 1'b1 || bus.busy !== 1'b1) early++;
            next();
        end
        chk({tag, "_busy_window"}, 64'(early), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.flush     = flush_in_done;
        #1;
        chk({tag, "_done_T33"},  64'(bus.done),  flush_in_done ? 64'd0 : 64'd1);
        chk({tag, "_stall_T33"}, 64'(bus.stall), 64'd0);
        chk({tag, "_busy_T33"},  64'(bus.busy),  64'd1);
        next();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        #1;
        chk({tag, "_busy_T34"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done_T34"}, 64'(bus.done), 64'd0);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
        next();
    endtask

    initial begin
        int early;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.src_a     = 32'd0;
        bus.src_b     = 32'd0;
        bus.flush     = 1'b0;
        next();
        next();
        #1;
        chk("rst_hi",    64'(bus.hi),    64'd0);
        chk("rst_lo",    64'(bus.lo),    64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        next();
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 1'b0);
        run_op(2'b00, 32'h37A6_F4DF, 32'd23, 32'd5, 32'd9, "prior", 1'b0);

        // Flush while BUSY: accept at T, flush during T+10.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.src_a     = 32'd3;
        bus.src_b     = 32'd4;
        next();
        bus.req_valid = 1'b0;
        early = 0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            if (bus.done !== 1'b0) early++;
            next();
        end
        bus.flush = 1'b1;
        #1;
        if (bus.done !== 1'b0) early++;
        chk("flush_no_done", 64'(early), 64'd0);
        next();
        bus.flush = 1'b0;
        #1;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_hi",   64'(bus.hi),   64'd5);
        chk("flush_lo",   64'(bus.lo),   64'd9);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "after_flush", 1'b0);

        run_op(2'b00, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "flush_done", 1'b1);

        // Request together with flush in IDLE is ignored.
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.flush     = 1'b1;
        #1 chk("idle_flush_stall", 64'(bus.stall), 64'd0);
        next();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        #1 chk("idle_flush_busy", 64'(bus.busy), 64'd0);
        next();

`ifdef MDU_DIV_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
        run_op(2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0", 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf", 1'b0);
        run_op(2'b10, 32'd95, 32'd10, 32'd5, 32'd9, "divu_95_10", 1'b0);
        bus.req_op = 2'b11;
`else
        for (int k = 0; k < 2; k++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = (k == 0) ? 2'b10 : 2'b11;
            bus.src_a     = 32'd100;
            bus.src_b     = 32'd0;
            #1 chk("nodiv_stall_T", 64'(bus.stall), 64'd1);
            next();
            bus.req_valid = 1'b0;
            #1;
            chk("nodiv_done_T1",  64'(bus.done),  64'd1);
            chk("nodiv_stall_T1", 64'(bus.stall), 64'd0);
            chk("nodiv_busy_T1",  64'(bus.busy),  64'd1);
            next();
            #1;
            chk("nodiv_busy_T2", 64'(bus.busy), 64'd0);
            chk("nodiv_hi", 64'(bus.hi), 64'hFFFF_FFFF);
            chk("nodiv_lo", 64'(bus.lo), 64'hFFFF_FFEB);
            next();
        end
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "nodiv_mul", 1'b0);
        bus.req_op = 2'b00;
`endif

        // Reset asserted between edges at T+20 of an operation.
        bus.req_valid = 1'b1;
        bus.src_a     = 32'hFFFF_FFF9;
        bus.src_b     = 32'd2;
        next();
        bus.req_valid = 1'b0;
        repeat (19) next();
        #2 reset = 1'b1;
        #1;
        chk("midrst_hi",    64'(bus.hi),    64'd0);
        chk("midrst_lo",    64'(bus.lo),    64'd0);
        chk("midrst_busy",  64'(bus.busy),  64'd0);
        chk("midrst_stall", 64'(bus.stall), 64'd0);
        chk("midrst_done",  64'(bus.done),  64'd0);
        next();
        reset = 1'b0;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 (single clock, all state on rising edge); reset in 1 (asynchronous, active-high).
REQ-002 SHALL have ports: req_valid in 1 (execute stage presents mul/div op); req_op in 2 (00 MULTU, 01 MULT, 10 DIVU, 11 DIV); src_a in 32 (multiplicand/dividend); src_b in 32 (multiplier/divisor); flush in 1 (abort from branch/exception).
REQ-003 SHALL have ports: stall out 1 (hold execute_enable low); done out 1 (one-cycle completion pulse); busy out 1 (FSM not IDLE); hi out 32 (HI register); lo out 32 (LO register).
REQ-004 SHALL have parameter N_ITER, default 32, meaning iteration count; only 32 is supported.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-006 SHALL, in IDLE with req_valid=1 and flush=0, latch operands and req_op, clear iteration counter, and enter BUSY next cycle.
REQ-007 SHALL drive stall combinationally high when (IDLE and req_valid and not flush) or BUSY, and low in DONE.
REQ-008 SHALL iterate one shift-add (mul) or restoring shift-subtract (div) step per cycle in BUSY; counter 0..31; leave BUSY for DONE after count 31.
REQ-009 SHALL give fixed latency: accept at cycle T, done=1 at cycle T+33, hi/lo valid from cycle T+34.
REQ-010 SHALL, in DONE, assert done, write hi/lo on that edge, and return to IDLE; a new req_valid in DONE is not accepted until IDLE.
REQ-011 SHALL, for MULTU, give {hi,lo} = unsigned 64-bit src_a*src_b.
REQ-012 SHALL, for MULT, operate on magnitudes and negate the 64-bit product when operand signs differ.
REQ-013 SHALL, for DIVU, give lo=quotient and hi=remainder, unsigned.
REQ-014 SHALL, for DIV, truncate toward zero; quotient negated if signs differ; remainder takes sign of src_a.
REQ-015 SHALL, for divide by zero (DIVU or DIV), give lo=32'hFFFFFFFF, hi=src_a, with normal latency.
REQ-016 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, give lo=32'h80000000, hi=0.
REQ-017 SHALL, on flush=1 in BUSY or DONE, go to IDLE next cycle, suppress done, leave hi/lo unchanged.
REQ-018 SHALL ignore req_valid when flush=1 in the same IDLE cycle.
REQ-019 SHALL make busy=1 exactly in BUSY and DONE.

Reset
REQ-020 SHALL, on reset asserted, immediately enter IDLE and force hi=0, lo=0, done=0, busy=0, stall=0, counter=0, irrespective of clk.
REQ-021 SHALL, on reset mid-operation, discard the operation; hi/lo read 0 after reset.
REQ-022 SHALL accept a request in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL compile the divider only when macro MDU_DIV_EN is defined.
REQ-024 SHALL, with MDU_DIV_EN defined, behave per REQ-013..016.
REQ-025 SHALL, without MDU_DIV_EN, treat req_op 10/11 as accepted-and-ignored: IDLE to DONE in one cycle (done at T+1), hi/lo unchanged, stall high only in the accept cycle; multiply unaffected.

Verification
REQ-026 SHALL cover MULTU 32'hFFFFFFFF*32'hFFFFFFFF -> done at T+33, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-027 SHALL cover MULT 32'hFFFFFFFD(-3)*7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; stall high T..T+32, low at T+33.
REQ-028 SHALL cover DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100/0 -> lo=32'hFFFFFFFF, hi=100.
REQ-029 SHALL cover a prior result in hi/lo (hi=5, lo=9), new MULTU, flush at T+10 -> IDLE at T+11, no done, hi=5, lo=9; next request accepted at T+11.
REQ-030 SHALL cover reset asserted at T+20 of a DIV between clock edges -> outputs 0 immediately; without MDU_DIV_EN, DIVU -> done at T+1, hi/lo unchanged.
